// File: rtl/lmfe_pkg.sv
// ---------------------------------------------------------------------------
// lmfe_pkg
// Shared constants and types for the LMFE pixel feeder.
//   IMG_W / IMG_H : default frame geometry (pixels per row / rows per frame)
//   PIX_W         : default pixel width
//   N_PIX         : default pixels per frame
//   feed_state_e  : feeder FSM state encoding
// ---------------------------------------------------------------------------
package lmfe_pkg;
   localparam int IMG_W = 128;
   localparam int IMG_H = 128;
   localparam int PIX_W = 8;
   localparam int N_PIX = IMG_W * IMG_H;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } feed_state_e;
endpackage

// File: rtl/lmfe_prefetch_fifo.sv
// ---------------------------------------------------------------------------
// lmfe_prefetch_fifo
// Two-entry prefetch buffer between the pixel memory and the LMFE output
// register. Head is combinational so the top can register it straight into
// Din on the pop edge.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low, empties the buffer
//   push   : write din this cycle
//   pop    : consume head this cycle (only when count != 0)
//   din    : write data
//   count  : current occupancy 0..2
//   head   : oldest entry
// ---------------------------------------------------------------------------
module lmfe_prefetch_fifo #(
   parameter int PIX_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [PIX_W-1:0] din,
   output logic [1:0]       count,
   output logic [PIX_W-1:0] head
);
   logic [PIX_W-1:0] mem_q [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         // The read credit in the top level must make these unreachable.
         assert (!(push && !pop && (count_q == 2'd2)));
         assert (!(pop && (count_q == 2'd0)));
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/lmfe_pixel_feeder.sv
// ---------------------------------------------------------------------------
// lmfe_pixel_feeder
// Streams a raster-order frame from a synchronous pixel memory into LMFE's
// Din/in_en port, one pixel per cycle while busy is low, in address order.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low, aborts any frame
//   start    : frame request, honoured in IDLE only
//   mem_rd   : memory read strobe (data returns one cycle later)
//   mem_addr : linear raster read address
//   mem_data : read data
//   busy     : LMFE backpressure, sampled on the launch edge
//   in_en    : registered pixel-valid to LMFE
//   Din      : registered pixel data to LMFE
//   done     : one-cycle pulse after the last pixel beat
// ---------------------------------------------------------------------------
module lmfe_pixel_feeder #(
   parameter int IMG_W  = lmfe_pkg::IMG_W,
   parameter int IMG_H  = lmfe_pkg::IMG_H,
   parameter int PIX_W  = lmfe_pkg::PIX_W,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [PIX_W-1:0]  mem_data,
   input  logic              busy,
   output logic              in_en,
   output logic [PIX_W-1:0]  Din,
   output logic              done
);
   import lmfe_pkg::*;

   localparam int NFRAME = IMG_W * IMG_H;
   localparam int CNT_W  = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NFRAME - 1);
   localparam logic [CNT_W-1:0]  ALL_BEATS = CNT_W'(NFRAME);

   feed_state_e       state_q, state_d;
   logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
   logic              inflight_q;
   logic              in_en_q;
   logic [PIX_W-1:0]  din_q;

   logic [1:0]        fifo_count;
   logic [PIX_W-1:0]  fifo_head;
   logic              pop;
   logic [2:0]        occ;
   logic              rd_ok;

   lmfe_prefetch_fifo #(
      .PIX_W (PIX_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (inflight_q),
      .pop   (pop),
      .din   (mem_data),
      .count (fifo_count),
      .head  (fifo_head)
   );

   // Launch whenever LMFE is not busy and a prefetched pixel is waiting.
   assign pop = !busy && (fifo_count != 2'd0) &&
                ((state_q == RUN) || (state_q == DRAIN));

   // Credit: buffered + in-flight pixels, minus the one leaving this cycle,
   // must stay below the buffer depth before another read is issued.
   assign occ   = {1'b0, fifo_count} + {2'b00, inflight_q};
   assign rd_ok = pop ? (occ < 3'd3) : (occ < 3'd2);

   assign mem_rd   = (state_q == RUN) && rd_ok;
   assign mem_addr = rd_cnt_q;

   always_comb begin
      state_d  = state_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               rd_cnt_d = '0;
               wr_cnt_d = '0;
            end
         end
         RUN: begin
            if (mem_rd) begin
               rd_cnt_d = rd_cnt_q + 1'b1;
               if (rd_cnt_q == LAST_ADDR) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // wr_cnt reaches N in the cycle the last beat is on in_en,
            // so DONE follows that cycle.
            if (wr_cnt_q == ALL_BEATS) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (pop) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         inflight_q <= 1'b0;
         in_en_q    <= 1'b0;
         din_q      <= '0;
      end else begin
         state_q    <= state_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         // Marks that mem_data carries a requested pixel this cycle; cleared
         // by reset so data from an aborted frame is never pushed.
         inflight_q <= mem_rd;
         in_en_q    <= pop;
         if (pop) begin
            din_q <= fifo_head;
         end
      end
   end

   assign in_en = in_en_q;
   assign Din   = din_q;
endmodule

// File: tb/tb_lmfe_pixel_feeder.sv
// ---------------------------------------------------------------------------
// tb_lmfe_pixel_feeder
// Self-checking bench for a 4x4 frame: exact latency, busy toggling, long
// busy hold, mid-frame reset, ignored start pulses and randomized images
// with random busy. The expected pixel stream is simply the image array in
// address order.
// ---------------------------------------------------------------------------
module tb_lmfe_pixel_feeder;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int N  = W * H;
   localparam int PW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic [PW-1:0] mem_data;
   logic          busy;
   logic          in_en;
   logic [PW-1:0] din;
   logic          done;

   logic [PW-1:0] img [N];

   int   pass_cnt = 0;
   int   chk_cnt  = 0;
   int   beat;
   int   done_cnt;
   int   rd_seen  = 0;
   int   stall_rd;
   int   busy_mode;
   int   hold_left;
   logic prev_busy;

   lmfe_pixel_feeder #(
      .IMG_W  (W),
      .IMG_H  (H),
      .PIX_W  (PW),
      .ADDR_W (AW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .mem_rd   (mem_rd),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .busy     (busy),
      .in_en    (in_en),
      .Din      (din),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Synchronous pixel memory: data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_rd) begin
         mem_data <= img[mem_addr];
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One cycle: sample outputs at the falling edge, check beats against the
   // image order and the busy seen at the preceding rising edge, then drive
   // the busy value for the next rising edge.
   task automatic tick();
      @(negedge clk);
      if (in_en) begin
         if (beat < N) check("din_order", din, img[beat]);
         else          check("extra_beat", beat, N - 1);
         check("beat_after_busy", prev_busy, 0);
         beat++;
      end
      if (done) begin
         check("done_beats", beat, N);
         done_cnt++;
      end
      if (mem_rd) rd_seen++;
      if (busy_mode == 3 && hold_left > 0 && hold_left < 45 && mem_rd) stall_rd++;
      case (busy_mode)
         0:       busy = 1'b0;
         1:       busy = ~busy;
         2:       busy = 1'($urandom_range(0, 1));
         default: begin
            if (beat >= 6 && hold_left > 0) begin
               busy = 1'b1;
               hold_left--;
            end else begin
               busy = 1'b0;
            end
         end
      endcase
      prev_busy = busy;
   endtask

   task automatic run_frame(input int mode, input bit exact, input bit pulse);
      int k;
      int rd_before;
      beat      = 0;
      done_cnt  = 0;
      busy_mode = mode;
      hold_left = 50;
      stall_rd  = 0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      if (exact) begin
         check("rd0_strobe", mem_rd, 1);
         check("rd0_addr", mem_addr, 0);
      end
      while (done_cnt == 0 && k < 400) begin
         if (exact) begin
            check($sformatf("in_en_k%0d", k), in_en, (k >= 3 && k <= 18));
            if (k >= 3 && k <= 18) check($sformatf("din_k%0d", k), din, img[k - 3]);
         end
         start = pulse && (k == 5 || k == 16);
         tick();
         k++;
      end
      start = 1'b0;
      check("frame_done_seen", done_cnt, 1);
      if (exact) check("done_cycle", k, 19);
      check("frame_beats", beat, N);
      rd_before = rd_seen;
      repeat (6) tick();
      check("idle_no_rd", rd_seen - rd_before, 0);
      check("single_done", done_cnt, 1);
      $display("frame mode=%0d beats=%0d cycles_to_done=%0d", mode, beat, k);
   endtask

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      busy      = 1'b0;
      prev_busy = 1'b0;
      busy_mode = 0;
      beat      = 0;
      done_cnt  = 0;
      hold_left = 0;
      stall_rd  = 0;
      for (int i = 0; i < N; i++) img[i] = PW'(i);

      #12;
      check("rst_in_en", in_en, 0);
      check("rst_din", din, 0);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_done", done, 0);
      @(negedge clk);
      reset = 1'b1;

      // Unthrottled frame with exact cycle-by-cycle expectations.
      run_frame(0, 1'b1, 1'b0);
      // busy toggling every cycle.
      run_frame(1, 1'b0, 1'b0);
      // busy held for 50 cycles after pixel 5.
      run_frame(3, 1'b0, 1'b0);
      check("hold_applied", hold_left, 0);
      check("hold_stall_rd", stall_rd, 0);
      // start pulses during RUN and DRAIN must be ignored.
      run_frame(0, 1'b1, 1'b1);

      // Reset while pixel 9 is on the output.
      busy_mode = 0;
      beat      = 0;
      done_cnt  = 0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 100 && beat < 10; k++) tick();
      check("reset_at_p9", beat, 10);
      #2 reset = 1'b0;
      #1;
      check("arst_in_en", in_en, 0);
      check("arst_din", din, 0);
      check("arst_mem_rd", mem_rd, 0);
      check("arst_mem_addr", mem_addr, 0);
      check("arst_done", done, 0);
      $display("mid-frame reset applied after beat %0d", beat);
      tick();
      tick();
      reset = 1'b1;
      run_frame(0, 1'b1, 1'b0);

      // Random images with random backpressure.
      for (int f = 0; f < 10; f++) begin
         for (int i = 0; i < N; i++) img[i] = PW'($urandom_range(0, 255));
         run_frame(2, 1'b0, 1'b0);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/lmfe_pixel_feeder.md
# lmfe_pixel_feeder

Frame-streaming source for the LMFE engine. It reads a raster-order image from a synchronous pixel memory and drives it into LMFE's `Din`/`in_en` port under LMFE's `busy` backpressure. It emits one pixel per cycle while `busy` is low, and never drops or duplicates a pixel. It replaces the bench-side pattern driver in system builds; LMFE's `out_valid`/`Dout` side is untouched.

## Interface
Parameters:
- `IMG_W`, 128, pixels per row
- `IMG_H`, 128, rows per frame
- `PIX_W`, 8, pixel width
- `ADDR_W`, 14, memory address width, must satisfy 2^ADDR_W ≥ IMG_W·IMG_H

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `start`  in  1  frame request, sampled in IDLE only
- `mem_rd`  out  1  memory read strobe
- `mem_addr`  out  ADDR_W  read address, linear raster index
- `mem_data`  in  PIX_W  read data, valid exactly 1 cycle after `mem_rd`
- `busy`  in  1  from LMFE; high means do not launch a new pixel
- `in_en`  out  1  to LMFE; pixel valid this cycle
- `Din`  out  PIX_W  to LMFE; pixel data
- `done`  out  1  one-cycle pulse after the last pixel is sent

## Operation
- Reset values: `in_en`=0, `Din`=0, `mem_rd`=0, `mem_addr`=0, `done`=0. FSM goes to IDLE, FIFO is emptied, counters are zeroed.
- FSM states:
  - IDLE → RUN when `start`=1.
  - RUN → DRAIN when the last read is issued (rd_cnt = N−1, with N = IMG_W·IMG_H).
  - DRAIN → DONE when the beat for pixel N−1 launches.
  - DONE → IDLE after 1 cycle; `done`=1 only in DONE.
- `start` is ignored outside IDLE.
- Reads:
  - In RUN, issue `mem_rd` with `mem_addr`=rd_cnt when fifo_count + inflight − pop < 2.
  - rd_cnt increments per issued read.
  - Returned `mem_data` is written into the FIFO the next cycle.
- FIFO: 2-entry prefetch. Overflow is impossible by the credit rule above; overflow is an assertion failure.
- Launch (pop): at a posedge where `busy`=0 and the FIFO is non-empty, register `Din`←head and `in_en`←1. Otherwise register `in_en`←0 and hold `Din`.
- Simultaneous FIFO write and pop in one cycle: allowed, count unchanged. A write to an empty FIFO does not bypass to `Din` in the same cycle.
- wr_cnt counts launched beats. Exactly N beats per frame, in address order 0..N−1.
- Reset mid-frame aborts immediately. In-flight read data returning after reset is discarded. The next `start` restarts at address 0.

## Timing
- `start` is sampled at edge T0.
  - `mem_rd` for address 0 is high in cycle T0+1.
  - Data is captured at T0+2.
  - The first `in_en` is high in cycle T0+3 if `busy` was low at T0+3. Latency is 3 cycles.
- `busy` behaviour:
  - `busy` is sampled at the same edge that registers `in_en`, so `in_en` in cycle k reflects `busy` at the start of cycle k.
  - LMFE therefore sees at most the beat already registered after raising `busy`. This is the established LMFE contract.
- Sustained throughput is 1 pixel/cycle with `busy` low. The frame takes N+3 cycles, plus `done`.
- `done` is high in the cycle after the cycle in which pixel N−1 has `in_en`=1.

## Structure
- `lmfe_pkg` holds:
  - constants `IMG_W`, `IMG_H`, `PIX_W`, `N_PIX`
  - FSM state typedef {IDLE, RUN, DRAIN, DONE}
- Sub-module `lmfe_prefetch_fifo`: 2-deep, PIX_W wide, with `push`, `pop`, `count`, `head`, and async active-low `reset`.
- The top level holds the FSM, rd_cnt/wr_cnt, the credit logic and the output registers.

## Test plan
- IMG_W=IMG_H=4, `mem_data`=addr[7:0], `busy`=0, `start` at T0:
  - `in_en` is high for cycles T0+3..T0+18 with `Din`=00..0F.
  - `done` is high in T0+19.
- Same image, `busy` toggling 1/0 each cycle: 16 beats, Din 00..0F strictly in order, no beat in a cycle following `busy`=1 at its edge.
- `busy` held high for 50 cycles after pixel 5: `in_en` is 0 throughout, `mem_rd` stalls with FIFO full, resume delivers 06 next, no loss or duplication.
- `reset` low during pixel 9:
  - all outputs go to reset values asynchronously.
  - A new `start` delivers 00..0F from address 0 with the same 3-cycle latency.
- `start` pulsed during RUN and DRAIN: ignored, one `done`, exactly 16 beats.
- Full 128×128, pattern1.dat in memory, feeder→LMFE, random `busy` as LMFE drives it: LMFE output matches golden1.dat for all 16384 pixels, zero errors.
